// File: rtl/adc_tx_sequencer_pkg.sv
// Shared definitions for the ADC sample transmit sequencer:
// state encodings, header default, frame length and the byte selector.
// Frame length depends on ADC_TX_CHECKSUM_EN (defined: 3 bytes with XOR checksum).
package adc_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_WAIT = 2'b10
  } state_t;

  localparam logic [3:0] HDR_NIB_DEF = 4'hA;
  localparam int         SAMPLE_W    = 12;

`ifdef ADC_TX_CHECKSUM_EN
  localparam int NBYTES = 3;
`else
  localparam int NBYTES = 2;
`endif

  // Byte idx of the frame built from a 12 b sample; byte0 carries the header nibble.
  function automatic logic [7:0] frame_byte(input logic [3:0]          hdr,
                                            input logic [SAMPLE_W-1:0] s,
                                            input logic [1:0]          idx);
    logic [7:0] b0, b1, res;
    b0 = {hdr, s[11:8]};
    b1 = s[7:0];
    case (idx)
      2'd0:    res = b0;
      2'd1:    res = b1;
`ifdef ADC_TX_CHECKSUM_EN
      2'd2:    res = b0 ^ b1;
`endif
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/adc_tx_sequencer_if.sv
// Sample-in / byte-out handshake bundle of the ADC transmit sequencer.
// master = sequencer side, slave = sample source plus responder side.
interface adc_tx_if #(
  parameter int DATA_W = 12
) ();
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              sample_ready;
  logic              start_tx;
  logic [7:0]        tx_data;
  logic              wait_tx;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  sample_valid, sample_data, wait_tx,
    output sample_ready, start_tx, tx_data, busy, timeout_err
  );

  modport slave (
    output sample_valid, sample_data, wait_tx,
    input  sample_ready, start_tx, tx_data, busy, timeout_err
  );
endinterface

// File: rtl/adc_tx_sequencer_tx_timeout_counter.sv
// Wait-cycle counter for a handshake initiator. Cleared while not waiting,
// counts while enabled and holds at TIMEOUT-1, where expired is raised.
module tx_timeout_counter #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] wcnt;

  assign expired = (wcnt == LAST);

  // Saturating wait counter; clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   wcnt <= 8'd0;
    else if (clear)               wcnt <= 8'd0;
    else if (enable && !expired)  wcnt <= wcnt + 8'd1;
  end
endmodule

// File: rtl/adc_tx_sequencer.sv
// ADC transmit sequencer: accepts one sample, splits it into header/data bytes
// and sends each with a start_tx / wait_tx handshake, aborting on timeout.
// Optional: ADC_TX_CHECKSUM_EN adds a third byte (byte0 ^ byte1).
// All outputs are registered and change together with the state register.
module adc_tx_sequencer
  import adc_tx_pkg::*;
#(
  parameter int         DATA_W  = 12,
  parameter logic [3:0] HDR_NIB = HDR_NIB_DEF,
  parameter int         TIMEOUT = 32
) (
  input  logic      clk_sys,
  input  logic      reset,
  adc_tx_if.master  bus
);
  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

  state_t              state;
  logic [1:0]          byte_idx;
  logic [SAMPLE_W-1:0] sample_q;
  logic [SAMPLE_W-1:0] s_ext;
  logic                start_q;
  logic [7:0]          data_q;
  logic                busy_q;
  logic                ready_q;
  logic                err_q;
  logic                expired;
  logic                wt_clear;
  logic                wt_enable;

  assign s_ext = SAMPLE_W'(bus.sample_data[DATA_W-1:0]);

  assign bus.start_tx     = start_q;
  assign bus.tx_data      = data_q;
  assign bus.busy         = busy_q;
  assign bus.sample_ready = ready_q;
  assign bus.timeout_err  = err_q;

  // Counter only runs in S_WAIT; it is zero on the first S_WAIT cycle.
  assign wt_clear  = (state != S_WAIT);
  assign wt_enable = (state == S_WAIT);

  tx_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk_sys),
    .rst_n   (reset),
    .clear   (wt_clear),
    .enable  (wt_enable),
    .expired (expired)
  );

  // Sequencer FSM; tx_data/start_tx are loaded on entry to S_SEND so they
  // are valid during the S_SEND cycle. wait_tx outside S_WAIT is ignored.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      byte_idx <= 2'd0;
      sample_q <= '0;
      start_q  <= 1'b0;
      data_q   <= 8'h00;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.sample_valid && ready_q) begin
            sample_q <= s_ext;
            byte_idx <= 2'd0;
            data_q   <= frame_byte(HDR_NIB, s_ext, 2'd0);
            start_q  <= 1'b1;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            state    <= S_SEND;
          end
        end
        S_SEND: state <= S_WAIT;
        S_WAIT: begin
          // A wait_tx on the expiry cycle still completes the byte.
          if (bus.wait_tx) begin
            if (byte_idx == LAST_IDX) begin
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              state   <= S_IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              data_q   <= frame_byte(HDR_NIB, sample_q, byte_idx + 2'd1);
              start_q  <= 1'b1;
              state    <= S_SEND;
            end
          end else if (expired) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc_tx_sequencer.sv
// Directed bench for adc_tx_sequencer: vector table of frames with a
// programmable-delay responder, plus hand sequences for reset, stale
// wait_tx and back-to-back acceptance.
module tb_adc_tx_sequencer;
  localparam int TMO = 32;
`ifdef ADC_TX_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic clk_sys = 1'b0;
  logic reset   = 1'b0;

  adc_tx_if #(.DATA_W(12)) bus ();

  adc_tx_sequencer #(.DATA_W(12), .HDR_NIB(4'hA), .TIMEOUT(TMO)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus.master)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [11:0] s;
    int          d0, d1, d2;
    bit          inj;
    logic [7:0]  e0, e1, e2;
    int          exp_sent;
    int          exp_tmo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Offers sample s and answers each start_tx with wait_tx d cycles later
  // (d counted from the start_tx cycle). tmo_k = negedge index after the
  // last start_tx where timeout_err was seen, 0 if none.
  task automatic run_frame(input logic [11:0] s, input int d0, input int d1, input int d2,
                           input bit inj, input bit keep,
                           output logic [7:0] got [3], output int nsent, output int tmo_k);
    int dly [3];
    int stray;
    bit done;
    dly   = '{d0, d1, d2};
    got   = '{default: 8'h00};
    nsent = 0;
    tmo_k = 0;
    stray = 0;
    done  = 1'b0;
    @(negedge clk_sys);
    check("ready_idle", bus.sample_ready, 1);
    bus.sample_valid = 1'b1;
    bus.sample_data  = s;
    @(negedge clk_sys);
    if (!keep) bus.sample_valid = 1'b0;
    for (int b = 0; b < NB; b++) begin
      check($sformatf("start_b%0d", b), bus.start_tx, 1);
      if (b == 0) check("ready_busy", bus.sample_ready, 0);
      got[b] = bus.tx_data;
      nsent++;
      if (inj && b == 0) bus.wait_tx = 1'b1;
      done = 1'b0;
      for (int k = 1; k <= TMO + 4; k++) begin
        @(negedge clk_sys);
        bus.wait_tx = 1'b0;
        if (bus.timeout_err) begin
          tmo_k = k;
          break;
        end
        if (k == dly[b] + 1) begin
          done = 1'b1;
          break;
        end
        if (bus.start_tx || bus.tx_data !== got[b] || !bus.busy) stray++;
        if (k == dly[b]) bus.wait_tx = 1'b1;
      end
      if (tmo_k != 0 || !done) break;
    end
    check("stray_activity", stray, 0);
    if (tmo_k == 0) check("resp_done", done, 1);
    check("busy_end", bus.busy, 0);
    check("ready_end", bus.sample_ready, 1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got [3];
    logic [7:0] exp_b [3];
    int nsent, tmo_k;
    bit seen;

    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.wait_tx      = 1'b0;

    // Reset held with a sample offered: nothing may start.
    bus.sample_valid = 1'b1;
    bus.sample_data  = 12'h3C7;
    repeat (3) @(negedge clk_sys);
    check("rst_start", bus.start_tx, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.sample_ready, 1);
    check("rst_data", bus.tx_data, 8'h00);
    check("rst_tmo", bus.timeout_err, 0);
    bus.sample_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk_sys);
    check("post_rst_idle", bus.busy, 0);

    // Frame table; timeout shows one cycle after the wcnt==TIMEOUT-1 cycle.
    vecs[0] = '{12'h3C7, 14, 14, 14, 1'b0, 8'hA3, 8'hC7, 8'h64, NB, 0};
    vecs[1] = '{12'h000,  1,  1,  1, 1'b0, 8'hA0, 8'h00, 8'hA0, NB, 0};
    vecs[2] = '{12'hFFF,  5,  3,  7, 1'b0, 8'hAF, 8'hFF, 8'h50, NB, 0};
    vecs[3] = '{12'h5A5, 32, 32, 32, 1'b0, 8'hA5, 8'hA5, 8'h00, NB, 0};
    vecs[4] = '{12'h123, 33,  5,  5, 1'b0, 8'hA1, 8'h00, 8'h00, 1, TMO + 1};
    vecs[5] = '{12'h0F0, 10, 33,  5, 1'b0, 8'hA0, 8'hF0, 8'h00, 2, TMO + 1};
    vecs[6] = '{12'h3C7,  9,  4,  4, 1'b1, 8'hA3, 8'hC7, 8'h64, NB, 0};
`ifdef ADC_TX_CHECKSUM_EN
    vecs[7] = '{12'h3C7, 14, 14, 40, 1'b0, 8'hA3, 8'hC7, 8'h64, 3, TMO + 1};
`else
    vecs[7] = '{12'h3C7, 14, 14, 40, 1'b0, 8'hA3, 8'hC7, 8'h64, 2, 0};
`endif

    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        // Stale wait_tx while idle must not disturb anything.
        @(negedge clk_sys);
        bus.wait_tx = 1'b1;
        @(negedge clk_sys);
        bus.wait_tx = 1'b0;
        check("stale_idle_busy", bus.busy, 0);
        check("stale_idle_start", bus.start_tx, 0);
      end
      run_frame(vecs[i].s, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].inj, 1'b0,
                got, nsent, tmo_k);
      exp_b = '{vecs[i].e0, vecs[i].e1, vecs[i].e2};
      check($sformatf("v%0d_sent", i), nsent, vecs[i].exp_sent);
      check($sformatf("v%0d_tmo", i), tmo_k, vecs[i].exp_tmo);
      for (int b = 0; b < vecs[i].exp_sent && b < 3; b++)
        check($sformatf("v%0d_byte%0d", i, b), got[b], exp_b[b]);
      @(negedge clk_sys);
      check($sformatf("v%0d_tmo_pulse", i), bus.timeout_err, 0);
      check($sformatf("v%0d_no_restart", i), bus.start_tx, 0);
    end

    // Valid held through a frame: re-accepted on the first idle cycle.
    run_frame(12'h456, 3, 3, 3, 1'b0, 1'b1, got, nsent, tmo_k);
    check("hold_byte0", got[0], 8'hA4);
    check("hold_byte1", got[1], 8'h56);
    @(negedge clk_sys);
    bus.sample_valid = 1'b0;
    check("hold_reaccept", bus.start_tx, 1);
    check("hold_reaccept_data", bus.tx_data, 8'hA4);
    seen = 1'b0;
    for (int k = 1; k <= TMO + 4; k++) begin
      @(negedge clk_sys);
      if (bus.timeout_err) begin
        check("hold_tmo_cycle", k, TMO + 1);
        seen = 1'b1;
        break;
      end
    end
    check("hold_tmo_seen", seen, 1);

    // Reset 5 cycles into S_WAIT of byte0: asynchronous return to idle.
    @(negedge clk_sys);
    bus.sample_valid = 1'b1;
    bus.sample_data  = 12'h3C7;
    @(negedge clk_sys);
    bus.sample_valid = 1'b0;
    check("mid_start", bus.start_tx, 1);
    repeat (5) @(negedge clk_sys);
    check("mid_busy_pre", bus.busy, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.sample_ready, 1);
    check("mid_rst_data", bus.tx_data, 8'h00);
    check("mid_rst_start", bus.start_tx, 0);
    @(negedge clk_sys);
    bus.wait_tx = 1'b1;
    @(negedge clk_sys);
    bus.wait_tx = 1'b0;
    reset = 1'b1;
    @(negedge clk_sys);
    check("mid_post_start", bus.start_tx, 0);
    check("mid_post_busy", bus.busy, 0);
    run_frame(12'h3C7, 14, 14, 14, 1'b0, 1'b0, got, nsent, tmo_k);
    check("clean_sent", nsent, NB);
    check("clean_tmo", tmo_k, 0);
    check("clean_byte0", got[0], 8'hA3);
    check("clean_byte1", got[1], 8'hC7);
    if (NB == 3) check("clean_byte2", got[2], 8'h64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
